// File: rtl/board_ram_arbiter.sv
// Round-robin arbiter for the single-port board RAM shared by the game FSM,
// apple placer and video scanner, with a built-in full-board clear sequence.
module board_ram_arbiter #(
    parameter int WIDTH  = 32,
    parameter int HEIGHT = 16,
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [2:0]  we,
    input  logic [14:0] req_x,
    input  logic [11:0] req_y,
    input  logic [11:0] req_din,
    output logic [2:0]  ack,
    output logic [3:0]  rdata,
    input  logic        clr,
    output logic        clr_busy,
    output logic [4:0]  ram_x,
    output logic [3:0]  ram_y,
    output logic [3:0]  ram_in,
    output logic        ram_rd,
    output logic        ram_wr,
    input  logic [3:0]  ram_out
);

    localparam logic [4:0] X_LAST   = 5'(WIDTH - 1);
    localparam logic [3:0] Y_LAST   = 4'(HEIGHT - 1);
    localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

    typedef enum logic [2:0] {IDLE, STROBE, WAIT, DONE, CLEAR} state_t;

    state_t     state;
    logic [1:0] last_grant;
    logic [1:0] grant;
    logic [1:0] lat_cnt;
    logic       clr_pending;
    logic       is_write;

    logic [1:0] next_grant;
    logic       sel_we;
    logic [4:0] sel_x;
    logic [3:0] sel_y;
    logic [3:0] sel_din;

    // First asserted request scanning upward from the requester after last_grant.
    function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
        logic [1:0] pick;
        logic       found;
        int         idx;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            idx = (int'(last) + k) % 3;
            if (!found && r[2'(idx)]) begin
                pick  = 2'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    always_comb begin
        next_grant = rr_pick(req, last_grant);
        sel_we     = we[next_grant];
        case (next_grant)
            2'd0: begin
                sel_x   = req_x[4:0];
                sel_y   = req_y[3:0];
                sel_din = req_din[3:0];
            end
            2'd1: begin
                sel_x   = req_x[9:5];
                sel_y   = req_y[7:4];
                sel_din = req_din[7:4];
            end
            default: begin
                sel_x   = req_x[14:10];
                sel_y   = req_y[11:8];
                sel_din = req_din[11:8];
            end
        endcase
    end

    assign clr_busy = clr_pending;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last_grant  <= 2'd2;
            grant       <= 2'd0;
            lat_cnt     <= 2'd0;
            clr_pending <= 1'b0;
            is_write    <= 1'b0;
            ack         <= 3'b000;
            rdata       <= 4'd0;
            ram_x       <= 5'd0;
            ram_y       <= 4'd0;
            ram_in      <= 4'd0;
            ram_rd      <= 1'b0;
            ram_wr      <= 1'b0;
        end else begin
            ack <= 3'b000;
            // A clear request arriving mid-transaction waits here until IDLE.
            if (clr && state != CLEAR) begin
                clr_pending <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (clr_pending || clr) begin
                        state  <= CLEAR;
                        ram_x  <= 5'd0;
                        ram_y  <= 4'd0;
                        ram_in <= 4'd0;
                        ram_wr <= 1'b1;
                    end else if (|req) begin
                        grant      <= next_grant;
                        last_grant <= next_grant;
                        is_write   <= sel_we;
                        ram_x      <= sel_x;
                        ram_y      <= sel_y;
                        ram_in     <= sel_din;
                        ram_wr     <= sel_we;
                        ram_rd     <= ~sel_we;
                        state      <= STROBE;
                    end
                end
                STROBE: begin
                    if (is_write) begin
                        ram_wr     <= 1'b0;
                        ack[grant] <= 1'b1;
                        state      <= DONE;
                    end else begin
                        lat_cnt <= 2'd0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (lat_cnt == LAT_LAST) begin
                        rdata      <= ram_out;
                        ram_rd     <= 1'b0;
                        ack[grant] <= 1'b1;
                        state      <= DONE;
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                CLEAR: begin
                    if (ram_x == X_LAST && ram_y == Y_LAST) begin
                        ram_wr      <= 1'b0;
                        clr_pending <= 1'b0;
                        state       <= IDLE;
                    end else if (ram_x == X_LAST) begin
                        ram_x <= 5'd0;
                        ram_y <= ram_y + 4'd1;
                    end else begin
                        ram_x <= ram_x + 5'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_board_ram_arbiter.sv
// Bench for board_ram_arbiter: directed vector table, corner-case sequences,
// and randomized requester traffic against a transaction-level model.
module tb_board_ram_arbiter;

    localparam int W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, clr;
    logic [2:0]  req, we, ack;
    logic [14:0] req_x;
    logic [11:0] req_y, req_din;
    logic [3:0]  rdata, ram_y, ram_in, ram_out;
    logic        clr_busy, ram_rd, ram_wr;
    logic [4:0]  ram_x;

    logic        rst3, clr3;
    logic [2:0]  req3, we3, ack3;
    logic [14:0] req_x3;
    logic [11:0] req_y3, req_din3;
    logic [3:0]  rdata3, ram_y3, ram_in3, ram_out3;
    logic        clr_busy3, ram_rd3, ram_wr3;
    logic [4:0]  ram_x3;

    board_ram_arbiter #(.WIDTH(32), .HEIGHT(16), .RD_LAT(1)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .req_x(req_x), .req_y(req_y),
        .req_din(req_din), .ack(ack), .rdata(rdata), .clr(clr), .clr_busy(clr_busy),
        .ram_x(ram_x), .ram_y(ram_y), .ram_in(ram_in), .ram_rd(ram_rd),
        .ram_wr(ram_wr), .ram_out(ram_out)
    );

    board_ram_arbiter #(.WIDTH(32), .HEIGHT(16), .RD_LAT(3)) dut3 (
        .clk(clk), .rst(rst3), .req(req3), .we(we3), .req_x(req_x3), .req_y(req_y3),
        .req_din(req_din3), .ack(ack3), .rdata(rdata3), .clr(clr3), .clr_busy(clr_busy3),
        .ram_x(ram_x3), .ram_y(ram_y3), .ram_in(ram_in3), .ram_rd(ram_rd3),
        .ram_wr(ram_wr3), .ram_out(ram_out3)
    );

    // Board RAM stand-in: combinational read, written on ram_wr or by the preload port.
    logic [3:0] mem [512];
    logic [3:0] ref_mem [512];
    logic       pre_we;
    logic [8:0] pre_a;
    logic [3:0] pre_d;
    always @(posedge clk) begin
        if (ram_wr) mem[{ram_y, ram_x}] <= ram_in;
        else if (pre_we) mem[pre_a] <= pre_d;
    end
    assign ram_out = mem[{ram_y, ram_x}];

    typedef struct {
        logic       rst;
        logic       clr;
        logic [2:0] req;
        logic [2:0] we;
        logic [4:0] x;
        logic [3:0] y;
        logic [3:0] din;
        logic [2:0] e_ack;
        logic       e_wr;
        logic       e_rd;
        logic       e_busy;
        logic [4:0] e_x;
        logic [3:0] e_y;
        logic [3:0] e_in;
        logic [3:0] e_rdata;
    } vec_t;

    vec_t vq[$];

    int checks = 0;
    int errors = 0;

    int         k, cyc, n_wr, ord_err, bad_ack, bad_rd, lat, rd_cnt, overlap;
    int         free_at, last, exp_cyc, exp_g, g, addr;
    logic       exp_rd;
    logic [3:0] exp_val, last_val;
    logic [2:0] drop_next;
    logic [2:0] got_ack [6];
    logic [3:0] got_dat [6];
    int         rx [3] = '{3, 10, 20};
    int         ry [3] = '{9, 5, 1};

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic add_vec(input int rst_, clr_, req_, we_, x_, y_, din_,
                           e_ack_, e_wr_, e_rd_, e_busy_, e_x_, e_y_, e_in_, e_rdata_);
        vec_t v;
        v.rst = 1'(rst_);      v.clr = 1'(clr_);     v.req = 3'(req_);   v.we = 3'(we_);
        v.x = 5'(x_);          v.y = 4'(y_);         v.din = 4'(din_);
        v.e_ack = 3'(e_ack_);  v.e_wr = 1'(e_wr_);   v.e_rd = 1'(e_rd_); v.e_busy = 1'(e_busy_);
        v.e_x = 5'(e_x_);      v.e_y = 4'(e_y_);     v.e_in = 4'(e_in_); v.e_rdata = 4'(e_rdata_);
        vq.push_back(v);
    endtask

    task automatic build_vectors();
        //      rst clr req we  x  y din  ack wr rd busy x  y  in rdata
        add_vec(1,  0,  0,  0,  0, 0, 0,  0,  0, 0, 0,   0, 0, 0, 0);
        add_vec(0,  0,  0,  0,  0, 0, 0,  0,  0, 0, 0,   0, 0, 0, 0);
        add_vec(0,  0,  1,  1,  3, 9, 1,  0,  1, 0, 0,   3, 9, 1, 0);
        add_vec(0,  0,  1,  1,  7, 2, 5,  1,  0, 0, 0,   3, 9, 1, 0);
        add_vec(0,  0,  1,  1,  7, 2, 5,  0,  0, 0, 0,   3, 9, 1, 0);
        add_vec(0,  0,  0,  0,  0, 0, 0,  0,  0, 0, 0,   3, 9, 1, 0);
        add_vec(0,  0,  1,  0,  3, 9, 0,  0,  0, 1, 0,   3, 9, 0, 0);
        add_vec(0,  0,  1,  0,  3, 9, 0,  0,  0, 1, 0,   3, 9, 0, 0);
        add_vec(0,  0,  1,  0,  3, 9, 0,  1,  0, 0, 0,   3, 9, 0, 1);
        add_vec(0,  0,  1,  0,  3, 9, 0,  0,  0, 0, 0,   3, 9, 0, 1);
        add_vec(0,  0,  0,  0,  0, 0, 0,  0,  0, 0, 0,   3, 9, 0, 1);
        add_vec(0,  1,  0,  0,  0, 0, 0,  0,  1, 0, 1,   0, 0, 0, 1);
        add_vec(0,  0,  0,  0,  0, 0, 0,  0,  1, 0, 1,   1, 0, 0, 1);
        add_vec(1,  0,  0,  0,  0, 0, 0,  0,  0, 0, 0,   0, 0, 0, 0);
        add_vec(0,  0,  3,  0,  3, 9, 0,  0,  0, 1, 0,   3, 9, 0, 0);
        add_vec(0,  0,  3,  0,  3, 9, 0,  0,  0, 1, 0,   3, 9, 0, 0);
        add_vec(0,  0,  2,  0,  3, 9, 0,  1,  0, 0, 0,   3, 9, 0, 1);
        add_vec(0,  0,  2,  0,  3, 9, 0,  0,  0, 0, 0,   3, 9, 0, 1);
        add_vec(0,  0,  2,  0,  3, 9, 0,  0,  0, 1, 0,   3, 9, 0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; clr = 0; req = 0; we = 0; req_x = 0; req_y = 0; req_din = 0;
        rst3 = 1; clr3 = 0; req3 = 0; we3 = 0; req_x3 = 0; req_y3 = 0; req_din3 = 0; ram_out3 = 0;
        pre_we = 0; pre_a = 0; pre_d = 0;
        @(negedge clk);
        pre_we = 1;
        for (int a = 0; a < 512; a++) begin
            pre_a = 9'(a);
            pre_d = 4'($urandom);
            ref_mem[a] = pre_d;
            tick();
        end
        pre_we = 0;

        build_vectors();
        foreach (vq[i]) begin
            rst = vq[i].rst; clr = vq[i].clr; req = vq[i].req; we = vq[i].we;
            req_x = {3{vq[i].x}}; req_y = {3{vq[i].y}}; req_din = {3{vq[i].din}};
            tick();
            check($sformatf("vec%0d_ctrl", i), int'({ack, ram_wr, ram_rd, clr_busy}),
                  int'({vq[i].e_ack, vq[i].e_wr, vq[i].e_rd, vq[i].e_busy}));
            check($sformatf("vec%0d_addr", i), int'({ram_x, ram_y, ram_in}),
                  int'({vq[i].e_x, vq[i].e_y, vq[i].e_in}));
            check($sformatf("vec%0d_rdata", i), int'(rdata), int'(vq[i].e_rdata));
        end
        req = 0;
        ref_mem[9 * W + 3] = 4'd1;
        ref_mem[0] = 4'd0;
        ref_mem[1] = 4'd0;

        // Round robin with every requester reading continuously.
        rst = 1; tick(); rst = 0;
        we = 3'b000; req_x = {5'd20, 5'd10, 5'd3}; req_y = {4'd1, 4'd5, 4'd9}; req = 3'b111;
        k = 0; cyc = 0;
        while (k < 6 && cyc < 100) begin
            tick(); cyc++;
            if (ack != 0) begin
                got_ack[k] = ack; got_dat[k] = rdata; k++;
            end
        end
        check("rr_count", k, 6);
        for (int j = 0; j < 6; j++) begin
            g = (2 + 1 + j) % 3;
            check($sformatf("rr_ack%0d", j), int'(got_ack[j]), 1 << g);
            check($sformatf("rr_rdata%0d", j), int'(got_dat[j]), int'(ref_mem[ry[g] * W + rx[g]]));
        end
        req = 0;

        // Clear requested while requester 1's write is in flight; requester 2 waits it out.
        rst = 1; tick(); rst = 0;
        req = 3'b010; we = 3'b010; req_x = {5'd0, 5'd7, 5'd0}; req_y = {4'd0, 4'd4, 4'd0};
        req_din = {4'd0, 4'd6, 4'd0};
        tick();
        check("mclr_strobe_wr", int'(ram_wr), 1);
        clr = 1;
        tick();
        check("mclr_ack1", int'(ack), 2);
        check("mclr_busy_set", int'(clr_busy), 1);
        clr = 0;
        tick();
        req = 3'b100; we = 3'b000; req_x = {5'd3, 5'd7, 5'd0}; req_y = {4'd9, 4'd4, 4'd0};
        n_wr = 0; ord_err = 0; bad_ack = 0; bad_rd = 0; cyc = 0;
        do begin
            tick(); cyc++;
            if (ram_wr) begin
                if (ram_in != 0 || int'(ram_x) != n_wr % W || int'(ram_y) != n_wr / W) ord_err++;
                n_wr++;
            end
            if (ack != 0) bad_ack++;
            if (ram_rd) bad_rd++;
        end while (clr_busy && cyc < 2000);
        check("clr_wr_cycles", n_wr, 512);
        check("clr_order_errs", ord_err, 0);
        check("clr_no_ack", bad_ack, 0);
        check("clr_no_rd", bad_rd, 0);
        check("clr_busy_drop", int'(clr_busy), 0);
        for (int a = 0; a < 512; a++) ref_mem[a] = 4'd0;
        lat = 0;
        for (int c = 1; c <= 10 && lat == 0; c++) begin
            tick();
            if (ack != 0) lat = c;
        end
        check("clr_req2_lat", lat, 3);
        check("clr_req2_ack", int'(ack), 4);
        check("clr_req2_rdata", int'(rdata), int'(ref_mem[9 * W + 3]));
        req = 0;

        // Reset during a read's WAIT cycle, with a clear also pending.
        tick();
        req = 3'b001; we = 3'b000; req_x = {5'd0, 5'd0, 5'd5}; req_y = {4'd0, 4'd0, 4'd2};
        tick();
        clr = 1;
        tick();
        check("rstrd_pre_rd", int'(ram_rd), 1);
        check("rstrd_pre_busy", int'(clr_busy), 1);
        clr = 0; rst = 1;
        tick();
        check("rstrd_abort", int'({ram_rd, ram_wr, ack, clr_busy}), 0);
        rst = 0; req = 3'b111;
        lat = 0;
        for (int c = 1; c <= 10 && lat == 0; c++) begin
            tick();
            if (ack != 0) lat = c;
        end
        check("rstrd_first_grant", int'(ack), 1);
        req = 0;

        // Randomized requesters against a transaction-level model.
        rst = 1; tick(); rst = 0;
        free_at = 0; last = 2; exp_cyc = -1; exp_g = 0; exp_rd = 0; exp_val = 0;
        drop_next = 0; overlap = 0;
        for (int t = 0; t < 3000; t++) begin
            if (ack != 0 || t == exp_cyc) begin
                check("rnd_ack", int'(ack), (t == exp_cyc) ? (1 << exp_g) : 0);
                if (t == exp_cyc && exp_rd) check("rnd_rdata", int'(rdata), int'(exp_val));
            end
            if (ram_rd && ram_wr) overlap++;
            for (int i = 0; i < 3; i++) begin
                if (drop_next[2'(i)]) begin
                    req[2'(i)] = 0; drop_next[2'(i)] = 0;
                end else if (ack[2'(i)]) begin
                    drop_next[2'(i)] = 1;
                end else if (!req[2'(i)] && $urandom_range(0, 3) == 0) begin
                    req[2'(i)] = 1;
                    we[2'(i)] = 1'($urandom_range(0, 1));
                    req_x[4'(5 * i) +: 5] = 5'($urandom);
                    req_y[4'(4 * i) +: 4] = 4'($urandom);
                    req_din[4'(4 * i) +: 4] = 4'($urandom);
                end
            end
            if (t >= free_at && req != 0) begin
                g = last;
                do g = (g + 1) % 3; while (!req[2'(g)]);
                last = g;
                addr = int'(req_y[4'(4 * g) +: 4]) * W + int'(req_x[4'(5 * g) +: 5]);
                if (we[2'(g)]) begin
                    ref_mem[addr] = req_din[4'(4 * g) +: 4];
                    exp_rd = 0;
                    exp_cyc = t + 2;
                end else begin
                    exp_val = ref_mem[addr];
                    exp_rd = 1;
                    exp_cyc = t + 3;
                end
                exp_g = g;
                free_at = exp_cyc + 1;
            end
            tick();
        end
        check("rnd_rd_wr_overlap", overlap, 0);
        req = 0;

        // Three-cycle read latency instance.
        rst3 = 1; tick(); rst3 = 0;
        req3 = 3'b001; we3 = 3'b000; req_x3 = {5'd0, 5'd0, 5'd12}; req_y3 = {4'd0, 4'd0, 4'd7};
        rd_cnt = 0; lat = 0; last_val = 0;
        for (int c = 1; c <= 12 && lat == 0; c++) begin
            tick();
            ram_out3 = ram_out3 + 4'd1;
            if (ram_rd3) begin
                rd_cnt++;
                last_val = ram_out3;
            end
            if (ack3 != 0) begin
                lat = c;
                check("lat3_ack", int'(ack3), 1);
                check("lat3_rdata", int'(rdata3), int'(last_val));
                req3 = 0;
            end
        end
        check("lat3_rd_cycles", rd_cnt, 4);
        check("lat3_latency", lat, 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
